// File: rtl/ext_trig_pkg.sv
// Shared types and helpers for the external trigger receiver.
// Holds the FSM state encoding, default parameter values and a saturating increment.
package ext_trig_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUALIFY  = 3'd1,
    FIRE     = 3'd2,
    HOLDOFF  = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int WIDTH_W_DEF     = 8;
  localparam int HOLD_W_DEF      = 16;
  localparam int CNT_W_DEF       = 32;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ext_trig_rx_bit_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
// The last stage output is the only one safe to use in the clk domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ext_trig_rx.sv
// Receive-side conditioner for the shared external trigger line: synchronise,
// qualify by width, mask our own echoes, fire one pulse per event, then hold off.
module ext_trig_rx
  import ext_trig_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int WIDTH_W     = WIDTH_W_DEF,
  parameter int HOLD_W      = HOLD_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_trig_maroc,
  input  logic               pixel_trig_maroc,
  input  logic               enable,
  input  logic               own_mask_en,
  input  logic [WIDTH_W-1:0] min_width,
  input  logic [HOLD_W-1:0]  holdoff,
  input  logic               cnt_clr,
  output logic               trig_pulse,
  output logic               busy,
  output logic [CNT_W-1:0]   trig_count,
  output logic [15:0]        glitch_count,
  output logic [15:0]        self_count
);

  logic ext_s;
  logic own_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk (clk),
    .rst (rst),
    .d_i (ext_trig_maroc),
    .q_o (ext_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_own (
    .clk (clk),
    .rst (rst),
    .d_i (pixel_trig_maroc),
    .q_o (own_s)
  );

  state_t             state_q;
  logic [WIDTH_W-1:0] n_q;
  logic [WIDTH_W-1:0] qcnt_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [HOLD_W-1:0]  hcnt_q;
  logic               self_q;
  logic               trig_pulse_q;
  logic               busy_q;

  logic [CNT_W-1:0]   trig_count_q,  trig_count_d;
  logic [15:0]        glitch_count_q, glitch_count_d;
  logic [15:0]        self_count_q,   self_count_d;

  logic [WIDTH_W-1:0] n_now;
  logic [WIDTH_W-1:0] qcnt_inc;
  logic               self_now;
  logic               self_acc;
  logic               n_is_one;
  logic               qual_done;
  logic               inc_trig;
  logic               inc_glitch;
  logic               inc_self;

  // A zero qualify length behaves as a single-cycle qualify.
  assign n_now     = (min_width == '0) ? WIDTH_W'(1) : min_width;
  assign n_is_one  = (n_now == WIDTH_W'(1));
  assign qcnt_inc  = qcnt_q + WIDTH_W'(1);
  assign self_now  = own_s & own_mask_en;
  assign self_acc  = self_q | self_now;
  assign qual_done = (qcnt_inc == n_q);

  assign inc_trig   = (state_q == FIRE);
  assign inc_glitch = enable & (state_q == QUALIFY) & ~ext_s;
  assign inc_self   = enable & ext_s &
                      (((state_q == IDLE) & n_is_one & self_now) |
                       ((state_q == QUALIFY) & qual_done & self_acc));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= WIDTH_W'(1);
      qcnt_q       <= '0;
      hold_q       <= '0;
      hcnt_q       <= '0;
      self_q       <= 1'b0;
      trig_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      trig_pulse_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ext_s) begin
              // Event parameters are frozen here so mid-event writes are ignored.
              n_q    <= n_now;
              hold_q <= holdoff;
              self_q <= self_now;
              qcnt_q <= WIDTH_W'(1);
              busy_q <= 1'b1;
              if (!n_is_one) begin
                state_q <= QUALIFY;
              end else if (self_now) begin
                state_q <= WAIT_LOW;
              end else begin
                state_q      <= FIRE;
                trig_pulse_q <= 1'b1;
              end
            end
          end
          QUALIFY: begin
            if (!ext_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              qcnt_q <= qcnt_inc;
              self_q <= self_acc;
              if (qual_done) begin
                if (self_acc) begin
                  state_q <= WAIT_LOW;
                end else begin
                  state_q      <= FIRE;
                  trig_pulse_q <= 1'b1;
                end
              end
            end
          end
          FIRE: begin
            if (hold_q == '0) begin
              state_q <= WAIT_LOW;
            end else begin
              state_q <= HOLDOFF;
              hcnt_q  <= hold_q;
            end
          end
          HOLDOFF: begin
            if (hcnt_q == HOLD_W'(1)) begin
              state_q <= WAIT_LOW;
            end else begin
              hcnt_q <= hcnt_q - HOLD_W'(1);
            end
          end
          WAIT_LOW: begin
            if (!ext_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    trig_count_d   = trig_count_q;
    glitch_count_d = glitch_count_q;
    self_count_d   = self_count_q;
    if (inc_trig && (trig_count_q != '1)) begin
      trig_count_d = trig_count_q + CNT_W'(1);
    end
    if (inc_glitch) begin
      glitch_count_d = sat_inc16(glitch_count_q);
    end
    if (inc_self) begin
      self_count_d = sat_inc16(self_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      trig_count_q   <= '0;
      glitch_count_q <= '0;
      self_count_q   <= '0;
    end else begin
      trig_count_q   <= trig_count_d;
      glitch_count_q <= glitch_count_d;
      self_count_q   <= self_count_d;
    end
  end

  assign trig_pulse   = trig_pulse_q;
  assign busy         = busy_q;
  assign trig_count   = trig_count_q;
  assign glitch_count = glitch_count_q;
  assign self_count   = self_count_q;

endmodule
